// File: rtl/codix_mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
//   cmd_e   : requester / memory command encoding
//   resp_e  : response encoding returned to the requesters
//   state_e : arbiter transaction state
//   port_e  : requester identity (grant / ownership)
package codix_mem_arb_pkg;

  localparam int TIMEOUT_CYCLES_DEFAULT = 255;

  typedef enum logic [2:0] {
    CMD_IDLE  = 3'b000,
    CMD_READ  = 3'b001,
    CMD_WRITE = 3'b010
  } cmd_e;

  typedef enum logic [2:0] {
    RESP_WAIT = 3'b000,
    RESP_ACK  = 3'b001,
    RESP_DATA = 3'b010,
    RESP_ERR  = 3'b100
  } resp_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RDATA,
    ST_DONE
  } state_e;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_e;

  // Timeout counter width: wide enough to reach the limit, never below 8 bits.
  function automatic int cnt_width(input int cycles);
    return ($clog2(cycles + 1) > 8) ? $clog2(cycles + 1) : 8;
  endfunction

endpackage

// File: rtl/codix_mem_arb_rr.sv
// Two-way round-robin selector (purely combinational).
//   req_i, req_d : active requests from the instruction / data ports
//   last_grant   : port that won the previous arbitration
//   gnt_valid    : at least one request is active
//   gnt          : winning port (on a tie, the one not granted last)
module codix_mem_arb_rr
  import codix_mem_arb_pkg::*;
(
  input  logic  req_i,
  input  logic  req_d,
  input  port_e last_grant,
  output logic  gnt_valid,
  output port_e gnt
);

  // NOTE: every combinationally driven signal gets a default first so no
  // path through the block leaves it unassigned (which would infer a latch).
  always_comb begin
    gnt_valid = req_i | req_d;
    gnt       = PORT_I;
    if (req_i && req_d) begin
      gnt = (last_grant == PORT_I) ? PORT_D : PORT_I;
    end else if (req_d) begin
      gnt = PORT_D;
    end
  end

endmodule

// File: rtl/codix_mem_arbiter.sv
// Arbitrates an instruction-fetch port (read only) and a data port onto one
// memory port, one transaction outstanding at a time.
//   CLK, RST                       : clock, asynchronous active-high reset
//   i_cmd/i_addr/i_size            : instruction request (WRITE treated as IDLE)
//   i_resp/i_rdata                 : instruction response and read data
//   d_cmd/d_addr/d_size/d_wdata    : data request
//   d_resp/d_rdata                 : data response and read data
//   m_cmd/m_addr/m_size/m_wdata    : registered memory request
//   m_resp/m_rvalid/m_rdata        : memory ACK, read strobe and read data
//   busy                           : a transaction is in flight
//   timeout_err                    : one-cycle pulse when a transaction times out
module codix_mem_arbiter
  import codix_mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [2:0]  i_cmd,
  input  logic [31:0] i_addr,
  input  logic [1:0]  i_size,
  output logic [2:0]  i_resp,
  output logic [31:0] i_rdata,
  input  logic [2:0]  d_cmd,
  input  logic [31:0] d_addr,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_wdata,
  output logic [2:0]  d_resp,
  output logic [31:0] d_rdata,
  output logic [2:0]  m_cmd,
  output logic [31:0] m_addr,
  output logic [1:0]  m_size,
  output logic [31:0] m_wdata,
  input  logic [2:0]  m_resp,
  input  logic        m_rvalid,
  input  logic [31:0] m_rdata,
  output logic        busy,
  output logic        timeout_err
);

  localparam int            CW      = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LIM = CW'(TIMEOUT_CYCLES);

  state_e        state_q, state_d;
  port_e         last_grant_q, owner_q, gnt;
  resp_e         done_resp_q;
  logic          gnt_valid, req_i, req_d, ack, timeout;
  logic [CW-1:0] cnt_q, cnt_nxt;

  assign req_i = (i_cmd == CMD_READ);
  assign req_d = (d_cmd == CMD_READ) || (d_cmd == CMD_WRITE);
  assign ack   = (m_resp == RESP_ACK);

  // cnt_nxt is the number of cycles spent in the current wait state including
  // this one, so the limit is hit after exactly TIMEOUT_CYCLES waiting cycles.
  assign cnt_nxt = cnt_q + 1'b1;
  assign timeout = (cnt_nxt == CNT_LIM);

  codix_mem_arb_rr u_rr (
    .req_i      (req_i),
    .req_d      (req_d),
    .last_grant (last_grant_q),
    .gnt_valid  (gnt_valid),
    .gnt        (gnt)
  );

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic. ACK / read data take priority over a same-cycle timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (gnt_valid) state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (ack)          state_d = (m_cmd == CMD_WRITE) ? ST_DONE : ST_RDATA;
        else if (timeout) state_d = ST_DONE;
      end
      ST_RDATA:  if (m_rvalid || timeout) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Transaction datapath: memory request, ownership, timeout counter,
  // pending response and captured read data.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_grant_q <= PORT_I;
      owner_q      <= PORT_I;
      done_resp_q  <= RESP_WAIT;
      cnt_q        <= '0;
      m_cmd        <= CMD_IDLE;
      m_addr       <= '0;
      m_size       <= '0;
      m_wdata      <= '0;
      i_rdata      <= '0;
      d_rdata      <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (gnt_valid) begin
            owner_q      <= gnt;
            last_grant_q <= gnt;
            cnt_q        <= '0;
            m_cmd        <= (gnt == PORT_D) ? d_cmd   : CMD_READ;
            m_addr       <= (gnt == PORT_D) ? d_addr  : i_addr;
            m_size       <= (gnt == PORT_D) ? d_size  : i_size;
            m_wdata      <= (gnt == PORT_D) ? d_wdata : '0;
          end
        end
        ST_ACCESS: begin
          cnt_q <= cnt_nxt;
          if (ack) begin
            // Reads drop the request and restart the counter for RDATA.
            m_cmd       <= CMD_IDLE;
            cnt_q       <= '0;
            done_resp_q <= RESP_ACK;
          end else if (timeout) begin
            m_cmd       <= CMD_IDLE;
            done_resp_q <= RESP_ERR;
          end
        end
        ST_RDATA: begin
          cnt_q <= cnt_nxt;
          if (m_rvalid) begin
            if (owner_q == PORT_I) i_rdata <= m_rdata;
            else                   d_rdata <= m_rdata;
            done_resp_q <= RESP_DATA;
          end else if (timeout) begin
            done_resp_q <= RESP_ERR;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs: responses are only ever non-WAIT in DONE, and only to the owner.
  always_comb begin
    busy        = (state_q != ST_IDLE);
    i_resp      = RESP_WAIT;
    d_resp      = RESP_WAIT;
    timeout_err = 1'b0;
    if (state_q == ST_DONE) begin
      if (owner_q == PORT_I) i_resp = done_resp_q;
      else                   d_resp = done_resp_q;
      timeout_err = (done_resp_q == RESP_ERR);
    end
  end

endmodule

// File: tb/tb_codix_mem_arbiter.sv
// Self-checking bench for codix_mem_arbiter. The bench plays both requesters
// and the memory; expected values come from the transaction rules (who should
// win, what response a command earns, which data each port last received).
module tb_codix_mem_arbiter;
  import codix_mem_arb_pkg::*;

  localparam int TMO = 4;

  logic        CLK = 1'b0;
  logic        RST;
  logic [2:0]  i_cmd, i_resp, d_cmd, d_resp, m_cmd, m_resp;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic [1:0]  i_size, d_size, m_size;
  logic        m_rvalid, busy, timeout_err;

  always #5 CLK = ~CLK;

  codix_mem_arbiter #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLK(CLK), .RST(RST),
    .i_cmd(i_cmd), .i_addr(i_addr), .i_size(i_size), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_cmd(d_cmd), .d_addr(d_addr), .d_size(d_size), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata),
    .m_cmd(m_cmd), .m_addr(m_addr), .m_size(m_size), .m_wdata(m_wdata),
    .m_resp(m_resp), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .busy(busy), .timeout_err(timeout_err)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] exp_rdata_i = '0;
  logic [31:0] exp_rdata_d = '0;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] resp_of(input port_e p);
    return (p == PORT_I) ? i_resp : d_resp;
  endfunction

  function automatic logic [2:0] non_ack();
    logic [2:0] v;
    v = 3'($urandom_range(0, 7));
    if (v == RESP_ACK) v = RESP_WAIT;
    return v;
  endfunction

  task automatic drop_cmd(input port_e p);
    if (p == PORT_I) i_cmd = CMD_IDLE;
    else             d_cmd = CMD_IDLE;
  endtask

  task automatic check_rdata(input string tag);
    check({tag, "_i_rdata"}, i_rdata, exp_rdata_i);
    check({tag, "_d_rdata"}, d_rdata, exp_rdata_d);
  endtask

  // One full transaction. Called in an IDLE cycle with the requester(s)
  // already driving; 'who' is the port the rules say must win. Returns in the
  // IDLE cycle after DONE, so the caller can set up the next request.
  task automatic do_txn(input port_e who, input bit is_wr, input logic [31:0] addr,
                        input logic [1:0] size, input logic [31:0] wd, input logic [31:0] rd,
                        input int ack_dly, input int rv_dly, input bit keep,
                        input bit drop_early, input bit noise);
    port_e      oth;
    logic [2:0] exp_cmd;
    oth     = (who == PORT_I) ? PORT_D : PORT_I;
    exp_cmd = is_wr ? CMD_WRITE : CMD_READ;
    step();
    check("grant_cmd", m_cmd, exp_cmd);
    check("grant_addr", m_addr, addr);
    check("grant_size", m_size, size);
    if (is_wr) check("grant_wdata", m_wdata, wd);
    check("grant_busy", busy, 1'b1);
    if (drop_early) drop_cmd(who);
    for (int k = 0; k < ack_dly; k++) begin
      m_resp = non_ack();
      if (noise) begin
        m_rvalid = 1'b1;
        m_rdata  = $urandom();
      end
      step();
      check("hold_cmd", m_cmd, exp_cmd);
      check("hold_addr", m_addr, addr);
      check("wait_resp", resp_of(who), RESP_WAIT);
      check_rdata("access");
    end
    m_rvalid = 1'b0;
    m_resp   = RESP_ACK;
    step();
    m_resp = RESP_WAIT;
    if (!is_wr) begin
      check("rdata_cmd", m_cmd, CMD_IDLE);
      check("rdata_busy", busy, 1'b1);
      check("rdata_resp", resp_of(who), RESP_WAIT);
      for (int k = 0; k < rv_dly; k++) step();
      m_rvalid = 1'b1;
      m_rdata  = rd;
      step();
      m_rvalid = 1'b0;
      m_rdata  = $urandom();
      if (who == PORT_I) exp_rdata_i = rd;
      else               exp_rdata_d = rd;
    end
    check("done_resp", resp_of(who), is_wr ? RESP_ACK : RESP_DATA);
    check("done_other", resp_of(oth), RESP_WAIT);
    check("done_tmo", timeout_err, 1'b0);
    check("done_cmd", m_cmd, CMD_IDLE);
    check_rdata("done");
    if (!keep) drop_cmd(who);
    step();
    check("idle_resp", resp_of(who), RESP_WAIT);
    check("idle_busy", busy, 1'b0);
    check_rdata("idle");
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_tmo"}, timeout_err, 1'b0);
    check({tag, "_i_resp"}, i_resp, RESP_WAIT);
    check({tag, "_d_resp"}, d_resp, RESP_WAIT);
    check({tag, "_m_cmd"}, m_cmd, CMD_IDLE);
    check({tag, "_m_addr"}, m_addr, 32'h0);
    check({tag, "_m_size"}, m_size, 2'd0);
    check({tag, "_m_wdata"}, m_wdata, 32'h0);
    check_rdata(tag);
  endtask

  task automatic pulse_reset();
    #1 RST = 1'b1;
    #1;
    exp_rdata_i = '0;
    exp_rdata_d = '0;
    check_reset_outputs("rst_async");
    step();
    RST = 1'b0;
  endtask

  initial begin
    port_e       who;
    bit          wr;
    logic [31:0] addr, wd, rd;
    logic [1:0]  size;
    logic [31:0] ia [3];
    logic [31:0] da [3];

    RST = 1'b1;
    i_cmd = CMD_IDLE; i_addr = '0; i_size = '0;
    d_cmd = CMD_IDLE; d_addr = '0; d_size = '0; d_wdata = '0;
    m_resp = RESP_WAIT; m_rvalid = 1'b0; m_rdata = '0;
    step();
    step();
    check_reset_outputs("reset");
    RST = 1'b0;
    step();
    check("post_reset_busy", busy, 1'b0);

    // Instruction read: ACK after 2 cycles, read data 3 cycles after the ACK.
    i_cmd = CMD_READ; i_addr = 32'h100; i_size = 2'd2;
    do_txn(PORT_I, 1'b0, 32'h100, 2'd2, 32'h0, 32'hDEADBEEF, 2, 2, 1'b0, 1'b0, 1'b0);
    check("i_rdata_deadbeef", i_rdata, 32'hDEADBEEF);

    // Data write: wdata on the memory port at N+1, d_resp ACK at N+3.
    d_cmd = CMD_WRITE; d_addr = 32'h200; d_size = 2'd2; d_wdata = 32'h12345678;
    do_txn(PORT_D, 1'b1, 32'h200, 2'd2, 32'h12345678, 32'h0, 1, 0, 1'b0, 1'b0, 1'b0);

    // An instruction-port WRITE is not a request.
    i_cmd = CMD_WRITE;
    step();
    step();
    check("i_write_busy", busy, 1'b0);
    check("i_write_m_cmd", m_cmd, CMD_IDLE);
    i_cmd = CMD_IDLE;

    // Stray read strobe while idle, then while waiting for an ACK.
    m_rvalid = 1'b1; m_rdata = $urandom();
    step();
    m_rvalid = 1'b0;
    check("idle_rvalid_i_resp", i_resp, RESP_WAIT);
    check("idle_rvalid_d_resp", d_resp, RESP_WAIT);
    check_rdata("idle_rvalid");
    addr = $urandom(); rd = $urandom();
    i_cmd = CMD_READ; i_addr = addr; i_size = 2'd1;
    do_txn(PORT_I, 1'b0, addr, 2'd1, 32'h0, rd, 2, 1, 1'b0, 1'b0, 1'b1);

    // Round robin straight out of reset: D wins the first tie, then alternate.
    pulse_reset();
    for (int j = 0; j < 3; j++) begin
      ia[j] = {4'h1, 28'($urandom())};
      da[j] = {4'h2, 28'($urandom())};
    end
    i_cmd = CMD_READ; i_addr = ia[0]; i_size = 2'd2;
    d_cmd = CMD_READ; d_addr = da[0]; d_size = 2'd1;
    for (int k = 0; k < 6; k++) begin
      int j;
      j   = k / 2;
      who = (k % 2 == 0) ? PORT_D : PORT_I;
      do_txn(who, 1'b0, (who == PORT_D) ? da[j] : ia[j], (who == PORT_D) ? 2'd1 : 2'd2,
             32'h0, $urandom(), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
             (j < 2), 1'b0, 1'b0);
      if (j < 2) begin
        if (who == PORT_D) d_addr = da[j + 1];
        else               i_addr = ia[j + 1];
      end
    end

    // Randomized single-requester traffic, including early command drops.
    for (int n = 0; n < 12; n++) begin
      who  = ($urandom_range(0, 1) != 0) ? PORT_D : PORT_I;
      wr   = (who == PORT_D) && ($urandom_range(0, 1) != 0);
      addr = $urandom(); wd = $urandom(); rd = $urandom();
      size = 2'($urandom_range(0, 3));
      if (who == PORT_I) begin
        i_cmd = CMD_READ; i_addr = addr; i_size = size;
        d_cmd = CMD_IDLE;
      end else begin
        d_cmd = wr ? CMD_WRITE : CMD_READ; d_addr = addr; d_size = size; d_wdata = wd;
        i_cmd = ($urandom_range(0, 1) != 0) ? CMD_WRITE : CMD_IDLE;
      end
      do_txn(who, wr, addr, size, wd, rd, int'($urandom_range(0, 2)),
             int'($urandom_range(0, 2)), 1'b0, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)));
      i_cmd = CMD_IDLE;
    end

    // Timeout: memory never ACKs; ERR after TMO cycles in ACCESS.
    addr = $urandom();
    d_cmd = CMD_READ; d_addr = addr; d_size = 2'd2;
    step();
    check("tmo_grant_cmd", m_cmd, CMD_READ);
    for (int k = 0; k < TMO - 1; k++) begin
      m_resp = non_ack();
      step();
      check("tmo_wait_resp", d_resp, RESP_WAIT);
      check("tmo_wait_pulse", timeout_err, 1'b0);
      check("tmo_wait_busy", busy, 1'b1);
      check("tmo_wait_cmd", m_cmd, CMD_READ);
    end
    m_resp = non_ack();
    step();
    m_resp = RESP_WAIT;
    check("tmo_d_resp", d_resp, RESP_ERR);
    check("tmo_pulse", timeout_err, 1'b1);
    check("tmo_m_cmd", m_cmd, CMD_IDLE);
    check("tmo_i_resp", i_resp, RESP_WAIT);
    check_rdata("tmo");
    d_cmd = CMD_IDLE;
    step();
    check("tmo_pulse_end", timeout_err, 1'b0);
    check("tmo_resp_end", d_resp, RESP_WAIT);
    addr = $urandom(); rd = $urandom();
    i_cmd = CMD_READ; i_addr = addr; i_size = 2'd0;
    do_txn(PORT_I, 1'b0, addr, 2'd0, 32'h0, rd, 1, 1, 1'b0, 1'b0, 1'b0);

    // Reset while a data read waits for its data; late strobe is ignored,
    // then a tie after release goes to D again.
    d_cmd = CMD_READ; d_addr = $urandom(); d_size = 2'd2;
    step();
    m_resp = RESP_ACK;
    step();
    m_resp = RESP_WAIT;
    check("pre_rst_rdata_state", busy, 1'b1);
    check("pre_rst_m_cmd", m_cmd, CMD_IDLE);
    d_cmd = CMD_IDLE;
    pulse_reset();
    m_rvalid = 1'b1; m_rdata = $urandom();
    step();
    m_rvalid = 1'b0;
    check("late_rvalid_d_resp", d_resp, RESP_WAIT);
    check("late_rvalid_busy", busy, 1'b0);
    check_rdata("late_rvalid");
    ia[0] = $urandom(); da[0] = $urandom();
    i_cmd = CMD_READ; i_addr = ia[0]; i_size = 2'd2;
    d_cmd = CMD_READ; d_addr = da[0]; d_size = 2'd2;
    do_txn(PORT_D, 1'b0, da[0], 2'd2, 32'h0, $urandom(), 1, 1, 1'b0, 1'b0, 1'b0);
    do_txn(PORT_I, 1'b0, ia[0], 2'd2, 32'h0, $urandom(), 0, 0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
